// File: rtl/mpsoc_msp430_trace_term_monitor_if.sv
// Event stream from the trace/termination monitor to its consumer.
// master = monitor (drives the FIFO head), slave = consumer (drives ready).
interface mpsoc_msp430_trace_term_monitor_if #(
  parameter int DW = 16
);
  logic          ev_valid;
  logic          ev_ready;
  logic [4:0]    ev_core;
  logic [1:0]    ev_kind;
  logic [DW-1:0] ev_data;

  modport master (
    output ev_valid,
    output ev_core,
    output ev_kind,
    output ev_data,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_core,
    input  ev_kind,
    input  ev_data,
    output ev_ready
  );
endinterface

// File: rtl/mpsoc_msp430_trace_term_monitor.sv
// N-core MSP430 trace/termination monitor.
// Snoops each core's write-back trace, keeps command/argument register shadows,
// decodes marker instructions into EXIT/PUTC/REPORT events, holds one pending
// event per core, arbitrates round-robin into a shared event FIFO, and tracks
// per-core termination, all-terminated and a run watchdog.
module mpsoc_msp430_trace_term_monitor #(
  parameter int             NUM_CORES  = 8,
  parameter int             DW         = 16,
  parameter logic [DW-1:0]  MARK_INSN  = 16'h4303,
  parameter logic [3:0]     CMD_REG    = 4'd15,
  parameter logic [3:0]     ARG_REG    = 4'd14,
  parameter int             FIFO_DEPTH = 8,
  parameter int             TIMEOUT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      tr_valid,
  input  logic [NUM_CORES-1:0]      tr_wben,
  input  logic [4*NUM_CORES-1:0]    tr_wbreg,
  input  logic [DW*NUM_CORES-1:0]   tr_wbdata,
  input  logic [DW*NUM_CORES-1:0]   tr_insn,
  input  logic [TIMEOUT_W-1:0]      timeout_cycles,
  mpsoc_msp430_trace_term_monitor_if.master ev,
  output logic [NUM_CORES-1:0]      term,
  output logic                      all_term,
  output logic                      timeout,
  output logic [7:0]                drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] KIND_EXIT   = 2'd0;
  localparam logic [1:0] KIND_PUTC   = 2'd1;
  localparam logic [1:0] KIND_REPORT = 2'd2;

  // shadows and pending slots
  logic [DW-1:0]        cmd_sh_q   [NUM_CORES];
  logic [DW-1:0]        cmd_sh_d   [NUM_CORES];
  logic [DW-1:0]        arg_sh_q   [NUM_CORES];
  logic [DW-1:0]        arg_sh_d   [NUM_CORES];
  logic [NUM_CORES-1:0] pend_v_q, pend_v_d;
  logic [1:0]           pend_kind_q [NUM_CORES];
  logic [1:0]           pend_kind_d [NUM_CORES];
  logic [DW-1:0]        pend_data_q [NUM_CORES];
  logic [DW-1:0]        pend_data_d [NUM_CORES];

  // decode results
  logic [NUM_CORES-1:0] dec_v, dec_exit, drop, gnt_vec;
  logic [1:0]           dec_kind [NUM_CORES];
  logic [DW-1:0]        dec_data [NUM_CORES];

  // arbiter
  logic [4:0]           rr_ptr_q, rr_ptr_d;
  logic                 gnt_any;
  logic [4:0]           gnt_idx;
  logic [1:0]           gnt_kind;
  logic [DW-1:0]        gnt_data;

  // event FIFO
  logic [4:0]           fifo_core_q [FIFO_DEPTH];
  logic [4:0]           fifo_core_d [FIFO_DEPTH];
  logic [1:0]           fifo_kind_q [FIFO_DEPTH];
  logic [1:0]           fifo_kind_d [FIFO_DEPTH];
  logic [DW-1:0]        fifo_data_q [FIFO_DEPTH];
  logic [DW-1:0]        fifo_data_d [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt;
  logic                 fifo_full, fifo_empty, push, pop, can_push;

  // status
  logic [NUM_CORES-1:0] term_q, term_d;
  logic                 all_term_q, all_term_d;
  logic                 timeout_q, timeout_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = !fifo_empty && ev.ev_ready;
  assign can_push   = !fifo_full || pop;
  assign push       = gnt_any;

  assign ev.ev_valid = !fifo_empty;
  assign ev.ev_core  = fifo_empty ? 5'd0      : fifo_core_q[rd_ptr_q[AW-1:0]];
  assign ev.ev_kind  = fifo_empty ? 2'd0      : fifo_kind_q[rd_ptr_q[AW-1:0]];
  assign ev.ev_data  = fifo_empty ? {DW{1'b0}} : fifo_data_q[rd_ptr_q[AW-1:0]];

  assign term     = term_q;
  assign all_term = all_term_q;
  assign timeout  = timeout_q;
  assign drop_cnt = drop_cnt_q;

  // Shadow update and marker decode; decode sees the shadows as of the previous retirement.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      cmd_sh_d[i] = cmd_sh_q[i];
      arg_sh_d[i] = arg_sh_q[i];
      dec_v[i]    = 1'b0;
      dec_exit[i] = 1'b0;
      dec_kind[i] = KIND_EXIT;
      dec_data[i] = arg_sh_q[i];
      if (tr_valid[i] && tr_wben[i]) begin
        if (tr_wbreg[4*i +: 4] == CMD_REG) cmd_sh_d[i] = tr_wbdata[DW*i +: DW];
        if (tr_wbreg[4*i +: 4] == ARG_REG) arg_sh_d[i] = tr_wbdata[DW*i +: DW];
      end
      if (tr_valid[i] && (tr_insn[DW*i +: DW] == MARK_INSN)) begin
        case (cmd_sh_q[i])
          DW'(1): begin
            dec_v[i]    = 1'b1;
            dec_exit[i] = 1'b1;
            dec_kind[i] = KIND_EXIT;
          end
          DW'(4): begin
            dec_v[i]    = 1'b1;
            dec_kind[i] = KIND_PUTC;
            dec_data[i] = {{(DW-8){1'b0}}, arg_sh_q[i][7:0]};
          end
          DW'(2): begin
            dec_v[i]    = 1'b1;
            dec_kind[i] = KIND_REPORT;
          end
          default: ;
        endcase
      end
    end
  end

  // Round-robin grant: first pending core at or above the pointer, else first from zero.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = 5'd0;
    gnt_kind = 2'd0;
    gnt_data = {DW{1'b0}};
    if (can_push) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!gnt_any && pend_v_q[i] && (5'(i) >= rr_ptr_q)) begin
          gnt_any  = 1'b1;
          gnt_idx  = 5'(i);
          gnt_kind = pend_kind_q[i];
          gnt_data = pend_data_q[i];
        end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!gnt_any && pend_v_q[i]) begin
          gnt_any  = 1'b1;
          gnt_idx  = 5'(i);
          gnt_kind = pend_kind_q[i];
          gnt_data = pend_data_q[i];
        end
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) rr_ptr_d = (gnt_idx == 5'(NUM_CORES-1)) ? 5'd0 : gnt_idx + 5'd1;
  end

  // Pending slots, drop accounting and termination tracking.
  always_comb begin
    pend_v_d   = pend_v_q;
    term_d     = term_q | dec_exit;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      pend_kind_d[i] = pend_kind_q[i];
      pend_data_d[i] = pend_data_q[i];
      gnt_vec[i]     = gnt_any && (gnt_idx == 5'(i));
      drop[i]        = dec_v[i] && pend_v_q[i] && !gnt_vec[i];
      if (gnt_vec[i]) pend_v_d[i] = 1'b0;
      if (dec_v[i] && (!pend_v_q[i] || gnt_vec[i])) begin
        pend_v_d[i]    = 1'b1;
        pend_kind_d[i] = dec_kind[i];
        pend_data_d[i] = dec_data[i];
      end
      if (drop[i] && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  // Event FIFO write/read pointers and storage.
  always_comb begin
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      fifo_core_d[j] = fifo_core_q[j];
      fifo_kind_d[j] = fifo_kind_q[j];
      fifo_data_d[j] = fifo_data_q[j];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_core_d[wr_ptr_q[AW-1:0]] = gnt_idx;
      fifo_kind_d[wr_ptr_q[AW-1:0]] = gnt_kind;
      fifo_data_d[wr_ptr_q[AW-1:0]] = gnt_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // All-terminated flag and run watchdog; whichever of all_term/timeout comes first wins.
  always_comb begin
    all_term_d = &term_q;
    wd_cnt_d   = wd_cnt_q;
    if (!all_term_q) wd_cnt_d = wd_cnt_q + TIMEOUT_W'(1);
    timeout_d  = timeout_q ||
                 (!all_term_q && (timeout_cycles != '0) && (wd_cnt_d == timeout_cycles));
  end

  // State registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cmd_sh_q[i]    <= '0;
        arg_sh_q[i]    <= '0;
        pend_kind_q[i] <= '0;
        pend_data_q[i] <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_core_q[j] <= '0;
        fifo_kind_q[j] <= '0;
        fifo_data_q[j] <= '0;
      end
      pend_v_q   <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      term_q     <= '0;
      all_term_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_cnt_q <= '0;
      wd_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cmd_sh_q[i]    <= cmd_sh_d[i];
        arg_sh_q[i]    <= arg_sh_d[i];
        pend_kind_q[i] <= pend_kind_d[i];
        pend_data_q[i] <= pend_data_d[i];
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_core_q[j] <= fifo_core_d[j];
        fifo_kind_q[j] <= fifo_kind_d[j];
        fifo_data_q[j] <= fifo_data_d[j];
      end
      pend_v_q   <= pend_v_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      term_q     <= term_d;
      all_term_q <= all_term_d;
      timeout_q  <= timeout_d;
      drop_cnt_q <= drop_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_mpsoc_msp430_trace_term_monitor.sv
// Scoreboard bench for the trace/termination monitor: stimulus pushes expected
// events, a negedge monitor pops and compares every accepted FIFO head.
module tb_mpsoc_msp430_trace_term_monitor;

  localparam int NC = 8;
  localparam logic [15:0] MARK  = 16'h4303;
  localparam logic [15:0] OTHER = 16'h4F30;

  typedef struct packed {
    logic [4:0]  core;
    logic [1:0]  kind;
    logic [15:0] data;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   tr_valid, tr_wben;
  logic [4*NC-1:0] tr_wbreg;
  logic [16*NC-1:0] tr_wbdata, tr_insn;
  logic [31:0]     timeout_cycles;
  logic [NC-1:0]   term;
  logic            all_term, timeout;
  logic [7:0]      drop_cnt;

  int errors = 0;
  int checks = 0;
  ev_t exp_q[$];

  mpsoc_msp430_trace_term_monitor_if #(.DW(16)) evif ();

  mpsoc_msp430_trace_term_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .tr_valid       (tr_valid),
    .tr_wben        (tr_wben),
    .tr_wbreg       (tr_wbreg),
    .tr_wbdata      (tr_wbdata),
    .tr_insn        (tr_insn),
    .timeout_cycles (timeout_cycles),
    .ev             (evif),
    .term           (term),
    .all_term       (all_term),
    .timeout        (timeout),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // monitor: compare every accepted head against the scoreboard
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && evif.ev_valid && evif.ev_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ev_unexpected: got core=%0d kind=%0d data=%h, none expected",
                   evif.ev_core, evif.ev_kind, evif.ev_data);
        end else begin
          e = exp_q.pop_front();
          if (evif.ev_core !== e.core || evif.ev_kind !== e.kind || evif.ev_data !== e.data) begin
            errors++;
            $display("FAIL ev_match: got core=%0d kind=%0d data=%h, expected core=%0d kind=%0d data=%h",
                     evif.ev_core, evif.ev_kind, evif.ev_data, e.core, e.kind, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_tr();
    tr_valid  = '0;
    tr_wben   = '0;
    tr_wbreg  = '0;
    tr_wbdata = '0;
    tr_insn   = '0;
  endtask

  task automatic set_core(input int c, input logic wb, input logic [3:0] r,
                          input logic [15:0] d, input logic [15:0] ins);
    tr_valid[c]          = 1'b1;
    tr_wben[c]           = wb;
    tr_wbreg[4*c +: 4]   = r;
    tr_wbdata[16*c +: 16] = d;
    tr_insn[16*c +: 16]  = ins;
  endtask

  task automatic retire(input int c, input logic wb, input logic [3:0] r,
                        input logic [15:0] d, input logic [15:0] ins);
    clr_tr();
    set_core(c, wb, r, d, ins);
    tick();
    clr_tr();
  endtask

  task automatic expect_ev(input int c, input logic [1:0] k, input logic [15:0] d);
    ev_t e;
    e.core = 5'(c);
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    evif.ev_ready = 1'b0;
    timeout_cycles = '0;
    clr_tr();
    repeat (3) tick();
    check("rst_ev_valid", evif.ev_valid, 0);
    check("rst_ev_data",  {evif.ev_core, evif.ev_kind, evif.ev_data}, 0);
    check("rst_term",     term, 0);
    check("rst_all_term", all_term, 0);
    check("rst_timeout",  timeout, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    evif.ev_ready = 1'b1;

    // core2 PUTC with 2-cycle latency
    retire(2, 1'b1, 4'd15, 16'd4, OTHER);
    retire(2, 1'b1, 4'd14, 16'h0141, OTHER);
    expect_ev(2, 2'd1, 16'h0041);
    retire(2, 1'b0, 4'd0, 16'h0, MARK);
    check("putc_lat1_valid", evif.ev_valid, 0);
    tick();
    check("putc_lat2_valid", evif.ev_valid, 1);
    drain("putc_drain", 5);
    check("putc_term", term, 0);

    // ignored command and same-cycle shadow write
    retire(2, 1'b1, 4'd15, 16'd7, OTHER);
    retire(2, 1'b0, 4'd0, 16'h0, MARK);
    repeat (3) tick();
    check("cmd7_no_event", evif.ev_valid, 0);
    check("cmd7_drop_cnt", drop_cnt, 0);
    retire(2, 1'b1, 4'd15, 16'd4, MARK);       // old shadow 7 -> nothing
    repeat (3) tick();
    check("samecyc_old7", evif.ev_valid, 0);
    expect_ev(2, 2'd1, 16'h0041);
    retire(2, 1'b1, 4'd15, 16'd7, MARK);       // old shadow 4 -> PUTC
    drain("samecyc_old4_drain", 6);
    check("samecyc_drop_cnt", drop_cnt, 0);

    // FIFO overflow: 10 back-to-back markers with ready low
    evif.ev_ready = 1'b0;
    retire(0, 1'b1, 4'd15, 16'd4, OTHER);
    retire(0, 1'b1, 4'd14, 16'h0130, OTHER);
    for (int k = 0; k < 10; k++) begin
      clr_tr();
      set_core(0, 1'b1, 4'd14, 16'h0130 + 16'(k + 1), MARK);
      if (k < 9) expect_ev(0, 2'd1, 16'h0030 + 16'(k));
      tick();
    end
    clr_tr();
    repeat (2) tick();
    check("ovf_drop_cnt", drop_cnt, 1);
    check("ovf_head_valid", evif.ev_valid, 1);
    check("ovf_head_data", evif.ev_data, 16'h0030);
    tick();
    check("ovf_head_stable", {evif.ev_core, evif.ev_kind, evif.ev_data}, {5'd0, 2'd1, 16'h0030});
    evif.ev_ready = 1'b1;
    drain("ovf_drain", 30);
    tick();
    check("ovf_empty_after", evif.ev_valid, 0);
    check("ovf_drop_cnt_after", drop_cnt, 1);

    // reset with 5 queued events
    evif.ev_ready = 1'b0;
    retire(1, 1'b1, 4'd15, 16'd1, OTHER);
    for (int k = 0; k < 4; k++) begin
      clr_tr();
      set_core(0, 1'b0, 4'd0, 16'h0, MARK);
      if (k == 0) set_core(1, 1'b0, 4'd0, 16'h0, MARK);
      tick();
    end
    clr_tr();
    repeat (4) tick();
    check("prerst_valid", evif.ev_valid, 1);
    check("prerst_term", term, 8'h02);
    rst = 1'b1;
    tick();
    check("midrst_valid", evif.ev_valid, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_term", term, 0);

    // watchdog: core3 never exits, limit 100
    timeout_cycles = 32'd100;
    evif.ev_ready = 1'b1;
    tick();
    rst = 1'b0;
    clr_tr();
    for (int c = 0; c < NC; c++) if (c != 3) set_core(c, 1'b1, 4'd15, 16'd1, OTHER);
    tick();                                      // edge 1
    clr_tr();
    for (int c = 0; c < NC; c++) begin
      if (c != 3) begin
        set_core(c, 1'b0, 4'd0, 16'h0, MARK);
        expect_ev(c, 2'd0, 16'h0000);
      end
    end
    tick();                                      // edge 2
    clr_tr();
    for (int n = 3; n <= 99; n++) tick();
    check("wd_before_limit", timeout, 0);
    tick();                                      // edge 100
    check("wd_at_limit", timeout, 1);
    check("wd_all_term", all_term, 0);
    check("wd_term", term, 8'hF7);
    drain("wd_drain", 5);

    // all 8 cores EXIT in one cycle
    rst = 1'b1;
    timeout_cycles = '0;
    repeat (2) tick();
    rst = 1'b0;
    clr_tr();
    for (int c = 0; c < NC; c++) set_core(c, 1'b1, 4'd15, 16'd1, OTHER);
    tick();
    clr_tr();
    for (int c = 0; c < NC; c++) begin
      set_core(c, 1'b0, 4'd0, 16'h0, MARK);
      expect_ev(c, 2'd0, 16'h0000);
    end
    tick();
    clr_tr();
    check("exit_term", term, 8'hFF);
    check("exit_all_term_early", all_term, 0);
    tick();
    check("exit_all_term", all_term, 1);
    for (int k = 0; k < NC; k++) begin
      check("exit_burst_valid", evif.ev_valid, 1);
      check("exit_burst_core", evif.ev_core, k);
      tick();
    end
    check("exit_burst_done", evif.ev_valid, 0);
    check("exit_no_timeout", timeout, 0);
    drain("final_drain", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
